// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and restoring
// divider sharing one sequencer and one 64-bit accumulator; fixed 33-edge latency.
//   state  | meaning
//   S_IDLE | waiting for start; y holds last result
//   S_CALC | one multiply/divide iteration per edge, cnt 0..31
//   S_FIN  | sign fix, special cases, register y and pulse done
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] y
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic              r_sa;
    logic              r_sb;
    logic              r_bz;
    logic [XLEN-1:0]   r_ma;
    logic [XLEN-1:0]   r_mb;
    logic [2*XLEN-1:0] r_acc;
    logic [5:0]        r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_y;

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic [XLEN-1:0]   w_ma_in;
    logic [XLEN-1:0]   w_mb_in;
    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;

    always_comb begin
        w_sgn_a = a[XLEN-1] & ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110));
        w_sgn_b = b[XLEN-1] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
        w_ma_in = w_sgn_a ? -a : a;
        w_mb_in = w_sgn_b ? -b : b;
    end

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    always_comb begin
        w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_ma} : {(XLEN+1){1'b0}});
        w_mul_nxt = {w_add, r_acc[XLEN-1:1]};
    end

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
    always_comb begin
        w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = {1'b0, w_shift} - {2'b00, r_mb};
        w_div_nxt = w_diff[XLEN+1] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
    end

    // Signed overflow needs no special path: |a|/1 = 0x80000000 unnegated, remainder 0.
    // With b==0 the remainder path already reproduces a; only the quotient is forced.
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo  = r_bz ? {XLEN{1'b1}}
               : ((r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
        w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (r_op[2])
            w_res = r_op[1] ? w_rem : w_quo;
        else if (r_op[1:0] == 2'b00)
            w_res = w_prod[XLEN-1:0];
        else
            w_res = w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == 6'd31) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 3'b000;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_bz   <= 1'b0;
            r_ma   <= '0;
            r_mb   <= '0;
            r_acc  <= '0;
            r_cnt  <= 6'd0;
            r_done <= 1'b0;
            r_y    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_sa  <= w_sgn_a;
                        r_sb  <= w_sgn_b;
                        r_bz  <= (b == '0);
                        r_ma  <= w_ma_in;
                        r_mb  <= w_mb_in;
                        r_acc <= op[2] ? {{XLEN{1'b0}}, w_ma_in} : {{XLEN{1'b0}}, w_mb_in};
                        r_cnt <= 6'd0;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIN: begin
                    r_y    <= w_res;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign y    = r_y;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: expected results are queued at issue time and
// compared when done pulses; latency, handshake and reset behaviour checked inline.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    mdu_iter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
        logic [63:0] p;
        int ia;
        int ib;
        ia = xa;
        ib = xb;
        case (o)
            3'd0: begin p = {{32{xa[31]}}, xa} * {{32{xb[31]}}, xb}; return p[31:0]; end
            3'd1: begin p = {{32{xa[31]}}, xa} * {{32{xb[31]}}, xb}; return p[63:32]; end
            3'd2: begin p = {{32{xa[31]}}, xa} * {32'd0, xb}; return p[63:32]; end
            3'd3: begin p = {32'd0, xa} * {32'd0, xb}; return p[63:32]; end
            3'd4: begin
                if (xb == 0) return 32'hFFFFFFFF;
                if (xa == 32'h80000000 && xb == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (xb == 0) ? 32'hFFFFFFFF : xa / xb;
            3'd6: begin
                if (xb == 0) return xa;
                if (xa == 32'h80000000 && xb == 32'hFFFFFFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (xb == 0) ? xa : xa % xb;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = xa;
        b = xb;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL reset_y: got %h expected 00000000", y); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept: busy %b expected 0", busy); end
    endtask

    task automatic test_mul();
        logic [2:0]  t_op[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] t_a[4]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_b[4]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_e[4]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
            checks++; if (y !== exp) begin errors++; $display("FAIL mul_y[%0d]: got %h expected %h", i, y, exp); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] t_e[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1};
        int lat;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], 32'hFFFFFFF9, 32'd2, t_e[i]);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat != 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            checks++; if (y !== exp) begin errors++; $display("FAIL div_y[%0d]: got %h expected %h", i, y, exp); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  t_op[6] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] t_a[6]  = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] t_b[6]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] t_e[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        int lat;
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat != 33) begin errors++; $display("FAIL special_latency[%0d]: got %0d expected 33", i, lat); end
            checks++; if (y !== exp) begin errors++; $display("FAIL special_y[%0d]: got %h expected %h", i, y, exp); end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0]  o;
        logic [31:0] xa;
        logic [31:0] xb;
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            o  = 3'(i % 8);
            xa = $urandom;
            xb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            issue(o, xa, xb, model(o, xa, xb));
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat != 33) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 33", i, lat); end
            checks++;
            if (y !== exp) begin
                errors++;
                $display("FAIL rand_y[%0d] op %0d a %h b %h: got %h expected %h", i, o, xa, xb, y, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int nbusy = 0;
        int lat = 0;
        logic [31:0] exp = 32'd0;
        issue(3'd0, 32'd3, 32'd5, 32'd15);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k;
                    exp = sb_q.pop_front();
                    checks++; if (y !== exp) begin errors++; $display("FAIL ignore_y: got %h expected %h", y, exp); end
                end
            end
            if (k == 5 || k == 20) begin
                start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (lat != 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
        checks++; if (nbusy != 32) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 32", nbusy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2 = 0;
        int held_err = 0;
        logic [31:0] exp;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done(lat);
        exp = sb_q.pop_front();
        checks++; if (y !== exp) begin errors++; $display("FAIL b2b_first_y: got %h expected %h", y, exp); end
        start = 1'b1; op = 3'd3; a = 32'hFFFFFFFF; b = 32'd2;
        sb_q.push_back(32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy %b expected 1", busy); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat2 = k;
                break;
            end
            if (y !== 32'd14) held_err++;
        end
        exp = sb_q.pop_front();
        checks++; if (held_err != 0) begin errors++; $display("FAIL b2b_y_hold: %0d cycles changed, expected 0", held_err); end
        checks++; if (lat2 != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat2); end
        checks++; if (y !== exp) begin errors++; $display("FAIL b2b_second_y: got %h expected %h", y, exp); end
    endtask

    task automatic test_reset_mid_op();
        int ndone = 0;
        int lat;
        logic [31:0] exp;
        issue(3'd4, 32'd1000, 32'd3, 32'd333);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL midrst_y: got %h expected 00000000", y); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        issue(3'd6, 32'hFFFFFC18, 32'd7, 32'hFFFFFFFA);
        wait_done(lat);
        exp = sb_q.pop_front();
        checks++; if (lat != 33) begin errors++; $display("FAIL midrst_fresh_latency: got %0d expected 33", lat); end
        checks++; if (y !== exp) begin errors++; $display("FAIL midrst_fresh_y: got %h expected %h", y, exp); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit for the scpu execute stage; sits beside the ALU and takes the same rs1/rs2 operands.
- Its result feeds the writeback select mux, and `busy` stalls PC/regfile writes while an M-extension instruction is in flight.
- Fixed-latency shift-add multiplier and restoring divider share one 32-step sequencer.

Parameters:
XLEN, 32, operand/result width (only 32 is supported; `cnt` width derived as 6 bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
a  input  32  rs1 operand, sampled at accept edge
b  input  32  rs2 operand, sampled at accept edge
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse, result valid
y  output  32  result; holds last result until the next completion

Behaviour:
- Reset: state=IDLE, busy=0, done=0, y=0, cnt=0. `rst` has priority over everything, including `start`.
- A reset mid-operation aborts the operation; no `done` is produced.
- States: IDLE, CALC, FIN.
- IDLE with start=1 (accept edge E0):
  - latch op, sign flags and operand magnitudes;
  - signed flags: a for mulh/mulhsu/div/rem, b for mulh/div/rem;
  - set cnt=0, go to CALC.
- CALC: one iteration per edge on E1..E32; at E32 (cnt==31) go to FIN.
  - mul: 64-bit product register, shift-add on `|b|` LSB.
  - div: restoring step on 33-bit partial remainder; quotient bit = no-borrow.
- FIN, edge E33:
  - apply sign fix and special cases; register `y`; done<=1; state<=IDLE.
- Timing: busy is high during the 33 cycles between E0 and E33. done is high for exactly the one cycle after E33.
- Latency is fixed at 33 edges for all ops, including special cases.
- start while busy is ignored, with no effect on the in-flight op.
- start during the done cycle (state already IDLE) is accepted, giving back-to-back ops. The new op does not disturb y until its own E33.
- Sign fix:
  - product negated if sa^sb;
  - quotient negated if sa^sb;
  - remainder negated if sa.
- Result selection:
  - mul → low 32 bits of the product;
  - mulh/mulhsu/mulhu → high 32 bits of the product.
- Divide by zero (b==0):
  - div/divu → 0xFFFFFFFF;
  - rem/remu → a.
  - This is forced at FIN regardless of sign flags.
- Signed overflow (div/rem, a==0x80000000, b==0xFFFFFFFF): div → 0x80000000, rem → 0.
- Operands a/b/op may change freely after E0 without affecting the result.
- Inputs on non-accept cycles are don't-care.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles → busy=0, done=0, y=0.
  - start=1 with rst=1 → no op accepted.
- Multiply, each done exactly 33 edges after accept:
  - mul 7 × 0xFFFFFFFD → y=0xFFFFFFEB.
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed/unsigned divide:
  - div 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - rem 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - divu 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - remu → 1.
- Special cases:
  - div 0xFFFFFFFB/0 → 0xFFFFFFFF.
  - rem 0xFFFFFFFB/0 → 0xFFFFFFFB.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem 0x80000000/0xFFFFFFFF → 0.
- Handshake:
  - start pulsed at cycles 5 and 20 of a busy op → ignored, single done, result of first op only.
  - start held high during the done cycle → second op accepted, second done 33 edges later.
  - y holds the first result in between.
- Reset mid-op: assert rst at cycle 10 of CALC → busy=0 next cycle, no done pulse, y=0; a fresh op afterwards completes correctly.
